// File: rtl/dm_access_pkg.sv
// Shared definitions for the data-memory access unit: op encoding, FSM states
// and the alignment rule.
package dm_access_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LB  = 3'd1,
        OP_LBU = 3'd2,
        OP_LH  = 3'd3,
        OP_LHU = 3'd4,
        OP_SW  = 3'd5,
        OP_SB  = 3'd6,
        OP_SH  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_e;

    function automatic logic is_store(input op_e op);
        return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

    // Halfword ops need an even address and word ops need a 4-byte aligned one.
    function automatic logic misaligned(input op_e op, input logic [1:0] lsb);
        logic bad;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = lsb[0];
            OP_LW, OP_SW:         bad = |lsb;
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// Request/response handshake plus the dm_1k pin bundle of the access unit.
interface dm_access_unit_if
    import dm_access_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic              dm_we;
    logic              dm_lb_flag;
    logic [31:0]       dm_dout;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, dm_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
               dm_addr, dm_din, dm_we, dm_lb_flag
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, dm_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               dm_addr, dm_din, dm_we, dm_lb_flag
    );
endinterface

// File: rtl/dm_lane_align.sv
// Little-endian byte/halfword lane handling: store merge into a word and
// load extraction with sign or zero extension.
module dm_lane_align
    import dm_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  op_e         op,
    input  logic [1:0]  lane,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        merged = word;
        case (op)
            OP_SW:   merged = wdata;
            OP_SH:   merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            OP_SB:   merged[{lane, 3'b000} +: 8]      = wdata[7:0];
            default: merged = word;
        endcase
    end

    always_comb begin
        byte_sel  = word[{lane, 3'b000} +: 8];
        half_sel  = word[{lane[1], 4'b0000} +: 16];
        extracted = '0;
        case (op)
            OP_LW:   extracted = word;
            OP_LB:   extracted = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  extracted = {24'h000000, byte_sel};
            OP_LH:   extracted = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  extracted = {16'h0000, half_sel};
            default: extracted = '0;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Single-outstanding load/store unit in front of dm_1k; sub-word stores are
// performed as a word read-modify-write.
module dm_access_unit
    import dm_access_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
)(
    input  logic            clk,
    input  logic            rst,
    dm_access_unit_if.slave bus
);

    state_e      state;
    op_e         op_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [31:0] merged;
    logic [31:0] extracted;
    op_e         req_op;

    assign req_op         = op_e'(bus.req_op);
    assign bus.dm_lb_flag = 1'b0;

    // Lane logic works straight off dm_dout while in RD; results land in
    // dm_din / resp_rdata at the RD edge.
    dm_lane_align u_lane_align (
        .word      (bus.dm_dout),
        .wdata     (wdata_q),
        .op        (op_q),
        .lane      (lane_q),
        .merged    (merged),
        .extracted (extracted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            op_q           <= OP_LW;
            lane_q         <= 2'b00;
            wdata_q        <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.dm_we      <= 1'b0;
            bus.dm_addr    <= '0;
            bus.dm_din     <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.dm_we      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q          <= req_op;
                        lane_q        <= bus.req_addr[1:0];
                        wdata_q       <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        bus.dm_addr   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                        if (misaligned(req_op, bus.req_addr[1:0])) begin
                            state          <= S_RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else if (req_op == OP_SW) begin
                            state      <= S_WR;
                            bus.dm_we  <= 1'b1;
                            bus.dm_din <= bus.req_wdata;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (is_store(op_q)) begin
                        state      <= S_WR;
                        bus.dm_we  <= 1'b1;
                        bus.dm_din <= merged;
                    end else begin
                        state          <= S_RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= extracted;
                    end
                end
                S_WR: begin
                    state          <= S_RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= '0;
                end
                S_RESP: begin
                    state         <= S_IDLE;
                    bus.req_ready <= 1'b1;
                end
                default: begin
                    state         <= S_IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: a word memory stands in for dm_1k and a byte-array
// model predicts every response, latency and write.
module tb_dm_access_unit;
    import dm_access_pkg::*;

    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic rst;
    logic clear_mem;

    dm_access_unit_if #(.ADDR_W(AW)) bus ();

    dm_access_unit #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0]   mem [256];
    int            we_count;
    int            bad_align;
    logic [AW-1:0] last_we_addr;
    logic [31:0]   last_we_din;

    assign bus.dm_dout = mem[bus.dm_addr[9:2]];

    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            we_count  <= 0;
            bad_align <= 0;
        end else if (bus.dm_we) begin
            mem[bus.dm_addr[9:2]] <= bus.dm_din;
            we_count     <= we_count + 1;
            last_we_addr <= bus.dm_addr;
            last_we_din  <= bus.dm_din;
            if (bus.dm_addr[1:0] != 2'b00) bad_align <= bad_align + 1;
        end
    end

    // Reference model: memory as 1024 independent bytes.
    logic [7:0] model_mem [1024];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input op_e op);
        case (op)
            OP_LW, OP_SW:         return 4;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 1;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input int a, input int size, input bit sgn);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < size; i++) v = v | (32'(model_mem[a + i]) << (8 * i));
        if (sgn && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
        return v;
    endfunction

    task automatic model_step(input op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] rd);
        int size;
        int a;
        size = op_size(op);
        a    = int'(addr & 32'h3FF);
        err  = (a % size) != 0;
        rd   = '0;
        if (!err) begin
            if (op == OP_SW || op == OP_SB || op == OP_SH) begin
                for (int i = 0; i < size; i++) model_mem[a + i] = 8'(wdata >> (8 * i));
            end else begin
                rd = model_read(a, size, op == OP_LB || op == OP_LH);
            end
        end
    endtask

    function automatic int model_lat(input op_e op, input logic err);
        if (err) return 1;
        if (op == OP_SB || op == OP_SH) return 3;
        return 2;
    endfunction

    task automatic issue(input op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_we;
        int          we_before;
        int          lat;
        bit          got;
        logic        err;
        string       t;
        t = $sformatf("%s@%03h", op.name(), addr[9:0]);
        model_step(op, addr, wdata, exp_err, exp_rd);
        exp_lat = model_lat(op, exp_err);
        exp_we  = (!exp_err && (op == OP_SW || op == OP_SB || op == OP_SH)) ? 1 : 0;

        @(negedge clk);
        check({t, " ready_idle"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        we_before     = we_count;
        @(posedge clk);
        #1;
        // Junk held on the request port while busy must be ignored.
        bus.req_op    = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        got   = 1'b0;
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) check({t, " ready_busy"}, 32'(bus.req_ready), 32'd0);
            if (bus.resp_valid) begin
                got   = 1'b1;
                lat   = k;
                rdata = bus.resp_rdata;
                err   = bus.resp_err;
                break;
            end
        end
        bus.req_valid = 1'b0;
        check({t, " resp_seen"}, 32'(got), 32'd1);
        check({t, " latency"}, 32'(lat), 32'(exp_lat));
        check({t, " resp_rdata"}, rdata, exp_rd);
        check({t, " resp_err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        check({t, " resp_pulse"}, 32'(bus.resp_valid), 32'd0);
        check({t, " ready_after"}, 32'(bus.req_ready), 32'd1);
        check({t, " write_count"}, 32'(we_count - we_before), 32'(exp_we));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    op_e         bop [4];
    logic [31:0] badr [4];
    logic [31:0] bwd [4];
    int          bsp [4];
    int          acc_cyc [4];
    logic [31:0] bexp [$];

    initial begin
        logic [31:0] rd;
        logic        e;
        logic [31:0] r;
        int          we_before;
        int          nacc;
        int          nresp;
        bit          pend;
        op_e         rop;
        logic [31:0] raddr;

        rst           = 1'b1;
        clear_mem     = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst resp_err", 32'(bus.resp_err), 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        check("rst dm_we", 32'(bus.dm_we), 32'd0);
        check("rst dm_addr", 32'(bus.dm_addr), 32'd0);
        check("rst dm_din", bus.dm_din, 32'd0);
        check("rst dm_lb_flag", 32'(bus.dm_lb_flag), 32'd0);
        clear_mem = 1'b0;
        rst       = 1'b0;

        // Word store then load back.
        issue(OP_SW, 32'h010, 32'h1122_3344, rd);
        check("sw dm_addr", 32'(last_we_addr), 32'h010);
        check("sw dm_din", last_we_din, 32'h1122_3344);
        issue(OP_LW, 32'h010, 32'h0, rd);
        check("lw value", rd, 32'h1122_3344);

        // Byte store read-modify-write.
        issue(OP_SB, 32'h012, 32'hFFFF_FFAB, rd);
        check("sb dm_addr", 32'(last_we_addr), 32'h010);
        check("sb dm_din", last_we_din, 32'h11AB_3344);
        issue(OP_LW, 32'h010, 32'h0, rd);
        check("lw after sb", rd, 32'h11AB_3344);

        // Sign and zero extension.
        issue(OP_SW, 32'h020, 32'h0000_8000, rd);
        issue(OP_LB, 32'h021, 32'h0, rd);
        check("lb ext", rd, 32'hFFFF_FF80);
        issue(OP_LBU, 32'h021, 32'h0, rd);
        check("lbu ext", rd, 32'h0000_0080);
        issue(OP_LH, 32'h020, 32'h0, rd);
        check("lh ext", rd, 32'hFFFF_8000);
        issue(OP_LHU, 32'h020, 32'h0, rd);
        check("lhu ext", rd, 32'h0000_8000);

        // Misaligned requests.
        issue(OP_SW, 32'h030, 32'h5555_AAAA, rd);
        issue(OP_LH, 32'h031, 32'h0, rd);
        issue(OP_SW, 32'h032, 32'hDEAD_BEEF, rd);
        issue(OP_LW, 32'h030, 32'h0, rd);
        check("mem after err", rd, 32'h5555_AAAA);

        // Reset during the write cycle of a halfword store.
        issue(OP_SW, 32'h040, 32'h1234_5678, rd);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SH;
        bus.req_addr  = 32'h042;
        bus.req_wdata = 32'h0000_BEEF;
        we_before     = we_count;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("sh rd dm_we", 32'(bus.dm_we), 32'd0);
        @(negedge clk);
        check("sh wr dm_we", 32'(bus.dm_we), 32'd1);
        check("sh wr dm_addr", 32'(bus.dm_addr), 32'h040);
        check("sh wr dm_din", bus.dm_din, 32'hBEEF_5678);
        #1 rst = 1'b1;
        #1;
        check("abort dm_we async", 32'(bus.dm_we), 32'd0);
        @(negedge clk);
        check("abort resp_valid", 32'(bus.resp_valid), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort no resp", 32'(bus.resp_valid), 32'd0);
        end
        check("abort ready", 32'(bus.req_ready), 32'd1);
        check("abort no write", 32'(we_count - we_before), 32'd0);
        issue(OP_LW, 32'h040, 32'h0, rd);
        check("abort word kept", rd, 32'h1234_5678);

        // Randomized requests in a small window, with junk above the address width.
        for (int n = 0; n < 60; n++) begin
            rop   = op_e'(3'($urandom_range(0, 7)));
            raddr = 32'h200 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            raddr = raddr | ($urandom & 32'hFFFF_FC00);
            issue(rop, raddr, $urandom, rd);
        end

        // Back-to-back requests with req_valid held high.
        bop  = '{OP_SW, OP_SB, OP_LW, OP_LBU};
        badr = '{32'h100, 32'h101, 32'h100, 32'h101};
        bwd  = '{32'hCAFE_F00D, 32'h0000_005A, 32'h0, 32'h0};
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = bop[0];
        bus.req_addr  = badr[0];
        bus.req_wdata = bwd[0];
        we_before     = we_count;
        nacc  = 0;
        nresp = 0;
        pend  = 1'b0;
        for (int c = 0; c < 40 && nresp < 4; c++) begin
            if (bus.resp_valid) begin
                check($sformatf("b2b resp_order %0d", nresp), 32'(nresp < nacc), 32'd1);
                if (nresp < nacc) check($sformatf("b2b rdata %0d", nresp), bus.resp_rdata, bexp[nresp]);
                nresp++;
            end
            if (nacc < 4 && bus.req_ready) begin
                acc_cyc[nacc] = c;
                model_step(bop[nacc], badr[nacc], bwd[nacc], e, r);
                bexp.push_back(r);
                bsp[nacc] = model_lat(bop[nacc], e) + 1;
                nacc++;
                pend = 1'b1;
            end
            @(posedge clk);
            #1;
            if (pend) begin
                pend = 1'b0;
                if (nacc < 4) begin
                    bus.req_op    = bop[nacc];
                    bus.req_addr  = badr[nacc];
                    bus.req_wdata = bwd[nacc];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("b2b accepted", 32'(nacc), 32'd4);
        check("b2b responses", 32'(nresp), 32'd4);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b spacing %0d", i), 32'(acc_cyc[i + 1] - acc_cyc[i]), 32'(bsp[i]));
        check("b2b writes", 32'(we_count - we_before), 32'd2);
        check("b2b lw value", bexp[2], 32'hCAFE_5A0D);
        check("dm_addr aligned on writes", 32'(bad_align), 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Initiator-side load/store unit that sits between the CPU datapath and the 1 KiB byte-addressed data memory (`dm_1k`). It accepts one load or store request at a time over a valid/ready handshake and checks alignment. It drives the memory's addr/din/we/lb_flag pins. Sub-word stores are done as a word read-modify-write, and sub-word loads are returned sign- or zero-extended.

## Interface
Parameters:
- `ADDR_W`, default 10: memory address width, byte address.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_op`  in  3  operation: LW=0, LB=1, LBU=2, LH=3, LHU=4, SW=5, SB=6, SH=7.
- `req_addr`  in  32  byte address; only [ADDR_W-1:0] is used.
- `req_wdata`  in  32  store data; low byte or halfword is used for SB/SH.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result, already extended; 0 for stores and errors.
- `resp_err`  out  1  misaligned request; valid with resp_valid.
- `dm_addr`  out  ADDR_W  memory address, always word-aligned ([1:0]=0).
- `dm_din`  out  32  memory write data.
- `dm_we`  out  1  memory write enable; the memory commits on the rising edge.
- `dm_lb_flag`  out  1  tied to 0; byte extraction is done in this unit.
- `dm_dout`  in  32  memory read data, combinational from dm_addr.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch op, addr and wdata, then run the alignment check:
  - Error if LH/LHU/SH have addr[0]=1.
  - Error if LW/SW have addr[1:0]≠0.
  - Byte ops never error.
- Next state from IDLE:
  - Error → RESP with `resp_err`=1; no memory access.
  - SW → WR.
  - All others → RD.
- RD: `dm_addr`={addr[ADDR_W-1:2],2'b00}. Capture `dm_dout` into the word register at the end of the cycle. Loads then go to RESP; SB/SH go to WR.
- WR:
  - `dm_we`=1 and `dm_addr` = the word address.
  - SW: `dm_din`=wdata.
  - SB: the word register with the byte lane selected by addr[1:0] replaced by wdata[7:0].
  - SH: the word register with the halfword lane selected by addr[1] replaced by wdata[15:0].
  - Go to RESP.
- Byte lane order is little-endian: lane 0 = bits [7:0].
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
  - LB/LBU: select the lane by addr[1:0], sign- or zero-extend to 32 bits.
  - LH/LHU: select the halfword by addr[1], sign- or zero-extend to 32 bits.
  - LW: the word register unchanged.
- `dm_we` is high only in WR. `dm_addr` and `dm_din` are registered/held stable through RD and WR.
- There is no response backpressure; the consumer must take `resp_valid` when it is asserted.

## Timing
- Request accepted in cycle N (IDLE with `req_valid`=1).
- `resp_valid` cycle:
  - Loads: N+2.
  - SW: N+2, with the write committed at the end of N+1.
  - SB/SH: N+3, with the write committed at the end of N+2.
  - Error: N+1.
- `req_ready` returns high in the cycle after RESP.
- Minimum spacing between accepted requests: 3 cycles for loads and SW, 4 for SB/SH.
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `dm_we`=0, `dm_addr`=0, `dm_din`=0, `dm_lb_flag`=0.
- Reset asserted mid-operation aborts immediately. `dm_we` falls asynchronously, no partial write is committed on the next edge, and no `resp_valid` is issued for the aborted request.
- `req_*` inputs are ignored outside IDLE.

## Structure
- Package `dm_access_pkg`: op encoding constants, state enum, `ADDR_W` default.
- Sub-module `dm_lane_align` (combinational), containing:
  - Store merge: word, wdata, op, addr[1:0] → merged word.
  - Load extract: word, op, addr[1:0] → extended result.
- The FSM and registers live in `dm_access_unit`.

## Test plan
- SW 0x11223344 @0x010, then LW @0x010:
  - One `dm_we` pulse with `dm_addr`=0x010 and `dm_din`=0x11223344.
  - LW returns 0x11223344 at N+2.
- Memory 0x11223344 @0x010, SB 0xAB @0x012:
  - RD, then WR with `dm_din`=0x11AB3344.
  - Subsequent LW @0x010 returns 0x11AB3344.
- Word 0x00008000 @0x020:
  - LB @0x021 returns 0xFFFFFF80.
  - LBU @0x021 returns 0x00000080.
  - LH @0x020 returns 0xFFFF8000.
  - LHU @0x020 returns 0x00008000.
- LH @0x031 and SW @0x032:
  - `resp_err`=1 at N+1 with `resp_rdata`=0.
  - `dm_we` never asserted; memory unchanged.
- SH 0xBEEF @0x042 with `rst` pulsed during WR:
  - `dm_we` drops immediately; word @0x040 unchanged.
  - No `resp_valid`; `req_ready`=1 after reset.
- Back-to-back requests with `req_valid` held high: four requests are accepted at 3/4-cycle spacing, with exactly one `resp_valid` per request, in order.
